sfm_tcdm_responder: RTL and testbench

Memory-side responder for the TCDM port that the softmax accelerator drives as a master. It accepts one HCI-core request per cycle, performs byte-enabled writes or fixed-latency reads on an internal word array, and returns read data in request order. It is the slave endpoint used in standalone accelerator testbenches and FPGA bring-up. It provides deterministic grant-stall injection to exercise the streamer's handshakes.

---
 rtl/sfm_tcdm_responder.sv | 150 +++++++++++++++
 tb/tb_sfm_tcdm_responder.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sfm_tcdm_responder.sv
// sfm_tcdm_responder
// Memory-side TCDM slave for the softmax accelerator. It accepts one request
// per cycle and applies byte-enabled writes to an internal word array.
// Reads are returned in order after a fixed latency. A periodic one-cycle
// grant stall can be injected to exercise the master's handshake logic.

module sfm_tcdm_responder #(
    parameter int unsigned DATA_WIDTH       = 128,
    parameter int unsigned ADDR_WIDTH       = 32,
    parameter int unsigned MEM_WORDS        = 1024,
    parameter int unsigned RD_LATENCY       = 1,
    parameter int unsigned GNT_STALL_PERIOD = 0
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    clear_i,
    input  logic                    tcdm_req_i,
    output logic                    tcdm_gnt_o,
    input  logic [ADDR_WIDTH-1:0]   tcdm_add_i,
    input  logic                    tcdm_wen_i,
    input  logic [DATA_WIDTH/8-1:0] tcdm_be_i,
    input  logic [DATA_WIDTH-1:0]   tcdm_data_i,
    output logic                    tcdm_r_valid_o,
    output logic [DATA_WIDTH-1:0]   tcdm_r_data_o,
    output logic [31:0]             rd_cnt_o,
    output logic [31:0]             wr_cnt_o
);

    localparam int unsigned NB  = DATA_WIDTH / 8;
    localparam int unsigned OFS = $clog2(NB);
    localparam int unsigned IW  = $clog2(MEM_WORDS);

    // Stall counter only exists in a meaningful form when the period is >= 2.
    localparam bit          STALL_EN = (GNT_STALL_PERIOD >= 2);
    localparam int unsigned SCW      = STALL_EN ? $clog2(GNT_STALL_PERIOD) : 1;
    localparam logic [SCW-1:0] STALL_LAST =
        STALL_EN ? SCW'(GNT_STALL_PERIOD - 1) : '0;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic [SCW-1:0] stall_cnt_q, stall_cnt_d;
    logic           stall;
    logic           rd_gnt, wr_gnt;
    logic [IW-1:0]  idx;
    logic           unused_addr;

    // Low byte-offset bits and upper alias bits do not select a word.
    assign unused_addr = ^tcdm_add_i;
    assign idx         = tcdm_add_i[OFS +: IW];

    assign stall      = STALL_EN && (stall_cnt_q == STALL_LAST);
    assign tcdm_gnt_o = tcdm_req_i && !stall && !clear_i && rst_ni;
    assign rd_gnt     = tcdm_gnt_o &&  tcdm_wen_i;
    assign wr_gnt     = tcdm_gnt_o && !tcdm_wen_i;

    // Next value of the free-running stall counter (wraps at period-1).
    always_comb begin
        stall_cnt_d = '0;
        if (STALL_EN && (stall_cnt_q != STALL_LAST)) begin
            stall_cnt_d = stall_cnt_q + SCW'(1);
        end
    end

    // Stall counter runs every cycle regardless of traffic; clear restarts it.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Word array (never reset, survives clear)
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mem_q [MEM_WORDS];

    // Byte-enabled write of the granted word.
    always_ff @(posedge clk_i) begin
        if (wr_gnt) begin
            for (int unsigned b = 0; b < NB; b++) begin
                if (tcdm_be_i[b]) begin
                    mem_q[idx][8*b +: 8] <= tcdm_data_i[8*b +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read response pipeline
    // ------------------------------------------------------------------
    logic [RD_LATENCY-1:0] vld_q;
    logic [DATA_WIDTH-1:0] dat_q [RD_LATENCY];

    // Data stages only load behind a valid bit so the output word holds its
    // last delivered value while r_valid is low. Clear drops in-flight reads
    // and also suppresses the data shift so the held value is untouched.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            vld_q <= '0;
            for (int unsigned i = 0; i < RD_LATENCY; i++) begin
                dat_q[i] <= '0;
            end
        end else if (clear_i) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= rd_gnt;
            if (rd_gnt) begin
                dat_q[0] <= mem_q[idx];
            end
            for (int unsigned i = 1; i < RD_LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                if (vld_q[i-1]) begin
                    dat_q[i] <= dat_q[i-1];
                end
            end
        end
    end

    assign tcdm_r_valid_o = vld_q[RD_LATENCY-1];
    assign tcdm_r_data_o  = dat_q[RD_LATENCY-1];

    // ------------------------------------------------------------------
    // Transaction counters (wrap naturally at 2^32)
    // ------------------------------------------------------------------
    logic [31:0] rd_cnt_q, rd_cnt_d;
    logic [31:0] wr_cnt_q, wr_cnt_d;

    // Next counter values.
    always_comb begin
        rd_cnt_d = rd_cnt_q + (rd_gnt ? 32'd1 : 32'd0);
        wr_cnt_d = wr_cnt_q + (wr_gnt ? 32'd1 : 32'd0);
    end

    // Counter registers, zeroed by reset or clear.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    assign rd_cnt_o = rd_cnt_q;
    assign wr_cnt_o = wr_cnt_q;

endmodule

// File: tb/tb_sfm_tcdm_responder.sv
// Bench for sfm_tcdm_responder: three instances with different latency and
// stall settings share one stimulus stream. A cycle-level reference model
// (word array, due-time response table, stall arithmetic) checks every
// output of every instance each cycle; directed phases add literal checks.

module tb_sfm_tcdm_responder;
  localparam int NI = 3;
  localparam int MW = 1024;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         clear = 1'b0;
  logic         req = 1'b0;
  logic         wen = 1'b1;
  logic [31:0]  add = '0;
  logic [15:0]  be = '0;
  logic [127:0] wdata = '0;

  logic [NI-1:0] gnt, rvalid;
  logic [127:0]  rdata [NI];
  logic [31:0]   rcnt [NI];
  logic [31:0]   wcnt [NI];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Instance 0: latency 1, no stall. 1: latency 3, no stall. 2: latency 4, stall period 4.
  sfm_tcdm_responder #(.RD_LATENCY(1), .GNT_STALL_PERIOD(0)) u_a (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .tcdm_req_i(req), .tcdm_gnt_o(gnt[0]),
    .tcdm_add_i(add), .tcdm_wen_i(wen), .tcdm_be_i(be), .tcdm_data_i(wdata),
    .tcdm_r_valid_o(rvalid[0]), .tcdm_r_data_o(rdata[0]), .rd_cnt_o(rcnt[0]), .wr_cnt_o(wcnt[0]));
  sfm_tcdm_responder #(.RD_LATENCY(3), .GNT_STALL_PERIOD(0)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .tcdm_req_i(req), .tcdm_gnt_o(gnt[1]),
    .tcdm_add_i(add), .tcdm_wen_i(wen), .tcdm_be_i(be), .tcdm_data_i(wdata),
    .tcdm_r_valid_o(rvalid[1]), .tcdm_r_data_o(rdata[1]), .rd_cnt_o(rcnt[1]), .wr_cnt_o(wcnt[1]));
  sfm_tcdm_responder #(.RD_LATENCY(4), .GNT_STALL_PERIOD(4)) u_c (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .tcdm_req_i(req), .tcdm_gnt_o(gnt[2]),
    .tcdm_add_i(add), .tcdm_wen_i(wen), .tcdm_be_i(be), .tcdm_data_i(wdata),
    .tcdm_r_valid_o(rvalid[2]), .tcdm_r_data_o(rdata[2]), .rd_cnt_o(rcnt[2]), .wr_cnt_o(wcnt[2]));

  function automatic int lat(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 3 : 4);
  endfunction

  function automatic int per(input int k);
    return (k == 2) ? 4 : 0;
  endfunction

  task automatic chk(input string name, input int k, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst=%0d got=%h want=%h t=%0t", name, k, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [127:0] mmem [NI][MW];
  logic [31:0]  mrc [NI];
  logic [31:0]  mwc [NI];
  int           since [NI];
  logic [127:0] last [NI];
  logic         due_v [NI][8];
  logic [127:0] due_d [NI][8];
  bit           armed = 0;
  int           cyc = 0;

  initial begin
    for (int k = 0; k < NI; k++) begin
      for (int s = 0; s < 8; s++) begin
        due_v[k][s] = 1'b0;
        due_d[k][s] = '0;
      end
      mrc[k] = '0; mwc[k] = '0; since[k] = 0; last[k] = '0;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < NI; k++) begin
        bit st;
        bit g;
        int ix;
        int sl;
        sl = cyc % 8;
        st = 1'b0;
        if (per(k) >= 2) st = ((since[k] % per(k)) == per(k) - 1);
        g = req && !st && !clear && rst_n;
        if (armed) begin
          chk("gnt", k, 128'(gnt[k]), 128'(g));
          chk("r_valid", k, 128'(rvalid[k]), 128'(due_v[k][sl]));
          if (due_v[k][sl]) last[k] = due_d[k][sl];
          chk("r_data", k, rdata[k], last[k]);
          chk("rd_cnt", k, 128'(rcnt[k]), 128'(mrc[k]));
          chk("wr_cnt", k, 128'(wcnt[k]), 128'(mwc[k]));
        end
        // advance to the state after the coming rising edge
        due_v[k][sl] = 1'b0;
        if (!rst_n || clear) begin
          for (int s = 0; s < 8; s++) due_v[k][s] = 1'b0;
          mrc[k] = '0; mwc[k] = '0; since[k] = 0;
          if (!rst_n) last[k] = '0;
        end else begin
          since[k]++;
          ix = int'(add[13:4]);
          if (g && wen) begin
            mrc[k] = mrc[k] + 32'd1;
            due_v[k][(cyc + lat(k)) % 8] = 1'b1;
            due_d[k][(cyc + lat(k)) % 8] = mmem[k][ix];
          end else if (g) begin
            mwc[k] = mwc[k] + 32'd1;
            for (int b = 0; b < 16; b++)
              if (be[b]) mmem[k][ix][8*b +: 8] = wdata[8*b +: 8];
          end
        end
      end
      if (!rst_n) armed = 1;
      cyc++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set(input logic r, input logic w, input logic [31:0] a, input logic [15:0] b,
                     input logic [127:0] d);
    req = r; wen = w; add = a; be = b; wdata = d;
  endtask

  // Hold one request until every instance has granted it once.
  task automatic xfer(input logic w, input logic [31:0] a, input logic [15:0] b, input logic [127:0] d);
    logic [NI-1:0] got;
    bit done;
    got = '0;
    done = 0;
    set(1'b1, w, a, b, d);
    for (int n = 0; n < 8 && !done; n++) begin
      @(negedge clk);
      got |= gnt;
      done = &got;
      step();
    end
    chk("xfer_grant", 0, 128'(got), 128'(3'b111));
    set(1'b0, 1'b1, '0, '0, '0);
  endtask

  task automatic do_clear();
    set(1'b0, 1'b1, '0, '0, '0);
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  logic [11:0] gv;

  initial begin
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    // preload every word with its own index
    for (int w = 0; w < MW; w++) xfer(1'b0, 32'(w) << 4, 16'hFFFF, 128'(w));

    // reset with req held high
    rst_n = 1'b0;
    set(1'b1, 1'b1, '0, '0, '0);
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk("rst_gnt", 0, 128'(gnt), 128'(0));
      if (n > 0) begin
        chk("rst_rvalid", 0, 128'(rvalid), 128'(0));
        for (int k = 0; k < NI; k++) begin
          chk("rst_rdcnt", k, 128'(rcnt[k]), 128'(0));
          chk("rst_wrcnt", k, 128'(wcnt[k]), 128'(0));
        end
      end
      step();
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_gnt", 0, 128'(gnt), 128'(3'b111));
    step();
    set(1'b0, 1'b1, '0, '0, '0);

    // streaming reads of words 0..7 on the latency-3 instance
    do_clear();
    for (int i = 0; i < 11; i++) begin
      if (i < 8) set(1'b1, 1'b1, 32'(i) << 4, '0, '0);
      else set(1'b0, 1'b1, '0, '0, '0);
      @(negedge clk);
      if (i >= 3) begin
        chk("stream_vld", 1, 128'(rvalid[1]), 128'(1));
        chk("stream_data", 1, rdata[1], 128'(i - 3));
      end else begin
        chk("stream_idle", 1, 128'(rvalid[1]), 128'(0));
      end
      step();
    end

    // byte-enable write then read on the latency-1 instance
    do_clear();
    xfer(1'b0, 32'h40, 16'hFFFF, {128{1'b1}});
    xfer(1'b0, 32'h40, 16'h000F, '0);
    xfer(1'b1, 32'h40, '0, '0);
    @(negedge clk);
    chk("be_vld", 0, 128'(rvalid[0]), 128'(1));
    chk("be_data", 0, rdata[0], {{96{1'b1}}, 32'h0});
    chk("be_wrcnt", 0, 128'(wcnt[0]), 128'(2));
    chk("be_rdcnt", 0, 128'(rcnt[0]), 128'(1));
    chk("be_wrcnt", 2, 128'(wcnt[2]), 128'(2));
    step();

    // stall pattern with period 4, req held 12 cycles
    do_clear();
    set(1'b1, 1'b1, '0, '0, '0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      gv[i] = gnt[2];
      step();
    end
    set(1'b0, 1'b1, '0, '0, '0);
    chk("stall_pat", 2, 128'(gv), 128'(12'b0111_0111_0111));
    @(negedge clk);
    chk("stall_cnt", 2, 128'(rcnt[2]), 128'(9));
    step();

    // aliasing: byte address 0x4000 maps to word 0
    xfer(1'b0, 32'h0, 16'hFFFF, {16{8'hA5}});
    xfer(1'b1, 32'h4000, '0, '0);
    @(negedge clk);
    chk("alias_vld", 0, 128'(rvalid[0]), 128'(1));
    chk("alias_data", 0, rdata[0], {16{8'hA5}});
    step();

    // clear with two reads in flight on the latency-4 instance
    do_clear();
    set(1'b1, 1'b1, 32'h50, '0, '0); step();
    set(1'b1, 1'b1, 32'h60, '0, '0); step();
    set(1'b0, 1'b1, '0, '0, '0);     step();
    set(1'b1, 1'b1, 32'h50, '0, '0);
    clear = 1'b1;
    @(negedge clk);
    chk("clr_gnt", 2, 128'(gnt[2]), 128'(0));
    step();
    clear = 1'b0;
    for (int i = 4; i <= 8; i++) begin
      @(negedge clk);
      if (i == 4) begin
        chk("clr_rdcnt", 2, 128'(rcnt[2]), 128'(0));
        chk("clr_wrcnt", 2, 128'(wcnt[2]), 128'(0));
      end
      if (i < 8) begin
        chk("clr_novld", 2, 128'(rvalid[2]), 128'(0));
      end else begin
        chk("clr_vld", 2, 128'(rvalid[2]), 128'(1));
        chk("clr_data", 2, rdata[2], 128'(5));
      end
      step();
      set(1'b0, 1'b1, '0, '0, '0);
    end

    // random traffic with occasional clear and reset pulses
    for (int n = 0; n < 3000; n++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      clear = ($urandom_range(0, 39) == 0);
      set($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), $urandom, 16'($urandom),
          {$urandom, $urandom, $urandom, $urandom});
      step();
    end
    rst_n = 1'b1;
    clear = 1'b0;
    set(1'b0, 1'b1, '0, '0, '0);
    repeat (10) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
